// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
package ram_arb_pkg;

  // Default widths for a 4096 x 32 data RAM.
  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  // Requester indices.
  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  // Command held in the one-cycle RAM access stage.
  // Field widths come from the package defaults; the top-level
  // ADDR_W/DATA_W parameters must stay equal to them.
  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
    logic                  src;
  } ram_cmd_t;

endpackage

// File: rtl/ram_arb_select.sv
// Grant selection between the core (priority) and the DMA port, with a
// counter that limits how long the DMA port can be starved.
module ram_arb_select
  import ram_arb_pkg::*;
#(
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic m0_req,
  input  logic m1_req,
  output logic m0_gnt,
  output logic m1_gnt
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

  // Consecutive core grants taken while the DMA port was waiting.
  logic [3:0] consec_cnt;

  // Core wins unless the DMA port has already waited MAX_CONSEC grants.
  always_comb begin
    m0_gnt = m0_req && !(m1_req && (consec_cnt == MAX_CNT));
    m1_gnt = m1_req && !m0_gnt;
  end

  // Count core grants while DMA waits; clear once DMA is served or idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      consec_cnt <= '0;
    end else if (!m1_req || m1_gnt) begin
      consec_cnt <= '0;
    end else if (m0_gnt && (consec_cnt != MAX_CNT)) begin
      consec_cnt <= consec_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter and sequencer for the single-port data RAM. A granted
// command is registered into an access stage that drives the RAM for one
// cycle; read data returns to the issuing port one cycle later.
//
// Handshake: a requester holds req/we/addr/wdata stable until it sees gnt;
// the command is accepted in the cycle where req & gnt. gnt is
// combinational and at most one gnt is high per cycle. There is no other
// backpressure. Read data comes back with a one-cycle rvalid pulse two
// cycles after acceptance; writes produce no response.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int          ADDR_W     = DEF_ADDR_W,
  parameter int          DATA_W     = DEF_DATA_W,
  parameter int unsigned MAX_CONSEC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_store,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_data_out
);

  ram_cmd_t cmd_d;
  ram_cmd_t cmd_q;

  ram_arb_select #(
    .MAX_CONSEC(MAX_CONSEC)
  ) u_select (
    .clk    (clk),
    .rst    (rst),
    .m0_req (m0_req),
    .m1_req (m1_req),
    .m0_gnt (m0_gnt),
    .m1_gnt (m1_gnt)
  );

  // Build the access-stage command from whichever port was granted.
  always_comb begin
    cmd_d = '0;
    if (m0_gnt) begin
      cmd_d.valid = 1'b1;
      cmd_d.we    = m0_we;
      cmd_d.addr  = m0_addr;
      cmd_d.wdata = m0_wdata;
      cmd_d.src   = PORT_CORE;
    end else if (m1_gnt) begin
      cmd_d.valid = 1'b1;
      cmd_d.we    = m1_we;
      cmd_d.addr  = m1_addr;
      cmd_d.wdata = m1_wdata;
      cmd_d.src   = PORT_DMA;
    end
  end

  // Access stage register; async clear abandons any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q <= '0;
    end else begin
      cmd_q <= cmd_d;
    end
  end

  // Drive the RAM only while the access stage holds a command.
  always_comb begin
    ram_address = '0;
    ram_data_in = '0;
    ram_store   = 1'b0;
    ram_load    = 1'b0;
    if (cmd_q.valid) begin
      ram_address = cmd_q.addr;
      ram_data_in = cmd_q.wdata;
      ram_store   = cmd_q.we;
      ram_load    = !cmd_q.we;
    end
  end

  // Capture read data at the end of the access cycle for the issuing port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      if (cmd_q.valid && !cmd_q.we) begin
        if (cmd_q.src == PORT_DMA) begin
          m1_rvalid <= 1'b1;
          m1_rdata  <= ram_data_out;
        end else begin
          m0_rvalid <= 1'b1;
          m0_rdata  <= ram_data_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model of arbitration, memory and read timing.
module tb_ram_arbiter;

  localparam int ADDR_W     = 12;
  localparam int DATA_W     = 32;
  localparam int MAX_CONSEC = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
  logic [DATA_W-1:0] m0_wdata = '0, m1_wdata = '0;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in, ram_data_out;
  logic              ram_store, ram_load;

  ram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_CONSEC(MAX_CONSEC)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_store(ram_store), .ram_load(ram_load), .ram_data_out(ram_data_out)
  );

  // RAM macro stand-in: combinational read, write on rising edge.
  logic [DATA_W-1:0] ram_mem [4096];
  initial for (int i = 0; i < 4096; i++) ram_mem[i] = '0;
  always @(posedge clk) if (ram_store) ram_mem[ram_address] <= ram_data_in;
  assign ram_data_out = ram_mem[ram_address];

  // ---------------- reference model state ----------------
  logic [DATA_W-1:0] model_mem [4096];
  initial for (int i = 0; i < 4096; i++) model_mem[i] = '0;
  logic [DATA_W-1:0] exp_q0[$], exp_q1[$];
  int                due_q0[$], due_q1[$];
  logic [DATA_W-1:0] last_rdata [2];
  int                streak = 0;   // core grants in a row while DMA waited
  int                m1_wait = 0;  // cycles the current DMA request has waited
  int                cyc = 0;
  logic              last_wr_valid = 1'b0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_old = '0;
  logic              obs_g1;

  // Pending request per port, held until granted.
  logic              p_req [2];
  logic              p_we [2];
  logic [ADDR_W-1:0] p_addr [2];
  logic [DATA_W-1:0] p_wdata [2];

  int n_pass = 0;
  int n_total = 0;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input int p, input logic we, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    p_req[p] = 1'b1; p_we[p] = we; p_addr[p] = a; p_wdata[p] = d;
  endtask

  task automatic drive();
    m0_req = p_req[0]; m0_we = p_we[0]; m0_addr = p_addr[0]; m0_wdata = p_wdata[0];
    m1_req = p_req[1]; m1_we = p_we[1]; m1_addr = p_addr[1]; m1_wdata = p_wdata[1];
  endtask

  task automatic accept(input int p);
    if (p_we[p]) begin
      last_wr_valid = 1'b1;
      last_wr_addr  = p_addr[p];
      last_wr_old   = model_mem[p_addr[p]];
      model_mem[p_addr[p]] = p_wdata[p];
    end else if (p == 0) begin
      exp_q0.push_back(model_mem[p_addr[p]]); due_q0.push_back(cyc + 2);
    end else begin
      exp_q1.push_back(model_mem[p_addr[p]]); due_q1.push_back(cyc + 2);
    end
    p_req[p] = 1'b0;
  endtask

  task automatic check_return();
    logic ev0, ev1;
    ev0 = (due_q0.size() > 0) && (due_q0[0] == cyc);
    ev1 = (due_q1.size() > 0) && (due_q1[0] == cyc);
    check("m0_rvalid", m0_rvalid, ev0);
    check("m1_rvalid", m1_rvalid, ev1);
    if (ev0) begin last_rdata[0] = exp_q0.pop_front(); void'(due_q0.pop_front()); end
    if (ev1) begin last_rdata[1] = exp_q1.pop_front(); void'(due_q1.pop_front()); end
    check("m0_rdata", m0_rdata, last_rdata[0]);
    check("m1_rdata", m1_rdata, last_rdata[1]);
  endtask

  // One clock cycle: drive pending requests, check grants and returns.
  task automatic step();
    logic eg0, eg1;
    @(posedge clk); #1;
    cyc++;
    drive();
    @(negedge clk);
    eg0 = p_req[0] && !(p_req[1] && streak == MAX_CONSEC);
    eg1 = p_req[1] && !eg0;
    obs_g1 = m1_gnt;
    check("m0_gnt", m0_gnt, eg0);
    check("m1_gnt", m1_gnt, eg1);
    check_return();
    last_wr_valid = 1'b0;
    if (!p_req[1] || eg1) streak = 0;
    else if (eg0) streak++;
    if (eg1) begin
      check("m1_wait_bound", (m1_wait <= MAX_CONSEC), 1);
      m1_wait = 0;
    end else if (p_req[1]) m1_wait++;
    if (eg0) accept(0);
    if (eg1) accept(1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  {m0_gnt, m1_gnt}, 0);
    check({tag, "_rv"},   {m0_rvalid, m1_rvalid}, 0);
    check({tag, "_rd0"},  m0_rdata, 0);
    check({tag, "_rd1"},  m1_rdata, 0);
    check({tag, "_ram"},  {ram_store, ram_load, ram_address}, 0);
    check({tag, "_din"},  ram_data_in, 0);
  endtask

  // Reset asserted while the command accepted last cycle is in the RAM stage.
  task automatic reset_mid();
    logic wr;
    wr = last_wr_valid;
    @(posedge clk); #1;
    cyc++;
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    drive();
    check("store_before_rst", ram_store, wr);
    rst = 1'b1;
    #1;
    check_all_zero("in_rst");
    if (wr) model_mem[last_wr_addr] = last_wr_old;
    exp_q0.delete(); due_q0.delete(); exp_q1.delete(); due_q1.delete();
    last_rdata[0] = '0; last_rdata[1] = '0;
    streak = 0; m1_wait = 0;
    @(negedge clk);
    check_all_zero("in_rst2");
    rst = 1'b0;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 4095));
    return ADDR_W'($urandom_range(0, 15));
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
      last_rdata[p] = '0;
    end
    drive();
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Core write then read of 0x010.
    issue(0, 1'b1, 12'h010, 32'hDEADBEEF); step();
    issue(0, 1'b0, 12'h010, 32'h0);        step();
    drain(3);

    // DMA read of a never-written word.
    issue(1, 1'b0, 12'hFFF, 32'h0); step();
    drain(3);

    // Both ports busy: 0,0,0,0,1 grant pattern.
    for (int k = 0; k < 20; k++) begin
      if (!p_req[0]) issue(0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      if (!p_req[1]) issue(1, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      step();
      check("burst_pattern", obs_g1, (k % 5 == 4));
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    drain(3);

    // Core write then DMA read of the same word, back to back.
    issue(0, 1'b1, 12'h020, 32'h1);
    issue(1, 1'b0, 12'h020, 32'h0);
    drain(4);
    check("raw_0x020", last_rdata[1], 32'h1);

    // Reset during the access cycle of a write to 0x030.
    issue(0, 1'b1, 12'h030, 32'h55); step();
    reset_mid();
    issue(0, 1'b0, 12'h030, 32'h0); step();
    drain(3);
    check("abandoned_wr", last_rdata[0], 32'h0);

    // Fill 0x000..0x00F, then 16 back-to-back DMA reads.
    for (int i = 0; i < 16; i++) begin
      issue(0, 1'b1, ADDR_W'(i), $urandom); step();
    end
    for (int i = 0; i < 16; i++) begin
      issue(1, 1'b0, ADDR_W'(i), 32'h0); step();
    end
    drain(3);

    // Random mixed traffic.
    for (int k = 0; k < 500; k++) begin
      for (int p = 0; p < 2; p++)
        if (!p_req[p] && $urandom_range(0, 3) != 0)
          issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
      step();
    end
    p_req[0] = 1'b0; p_req[1] = 1'b0;
    drain(4);
    check("q0_drained", exp_q0.size(), 0);
    check("q1_drained", exp_q1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester arbiter and sequencer for the single-port 4096×32 data RAM. It shares the RAM between the core load/store unit (port 0, priority) and a loader/DMA master (port 1, fairness-guarded), and registers each granted command into a one-cycle RAM access stage. It drives the RAM's address, write data, store and load strobes, and returns read data with a registered valid pulse. It sits between the core/DMA interconnect and the RAM macro.

## Interface
- ADDR_W, 12: word address width; must match RAM depth.
- DATA_W, 32: data word width.
- MAX_CONSEC, 4: maximum consecutive port-0 grants while port 1 waits; range 1..15.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req / m1_req  in  1  request valid.
- m0_we / m1_we  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  word address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  combinational grant; the request is accepted in a cycle where req & gnt.
- m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid pulse.
- m0_rdata / m1_rdata  out  DATA_W  read data, held until that port's next rvalid.
- ram_address  out  ADDR_W  RAM address.
- ram_data_in  out  DATA_W  RAM write data.
- ram_store  out  1  RAM write strobe.
- ram_load  out  1  RAM read enable.
- ram_data_out  in  DATA_W  RAM combinational read data.

## Operation
- Request handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt.
  - At most one gnt is high per cycle.
  - The arbiter accepts one command per cycle; there is no backpressure beyond arbitration.
- Grant rule:
  - Only port 0 requesting: grant port 0.
  - Only port 1 requesting: grant port 1.
  - Both requesting: grant port 0 unless consec_cnt == MAX_CONSEC, in which case grant port 1.
- consec_cnt (4 bits):
  - Increments on a port-0 grant while m1_req=1.
  - Clears on any port-1 grant, or on any cycle with m1_req=0.
  - Saturates at MAX_CONSEC.
- Access stage:
  - The accepted command is latched into cmd_q = {valid, we, addr, wdata, src}.
  - While cmd_q.valid is set, ram_address = cmd_q.addr and ram_data_in = cmd_q.wdata.
  - Write commands assert ram_store; read commands assert ram_load.
  - With cmd_q.valid=0, all ram_* outputs are 0.
- Read return:
  - At the end of the access cycle, ram_data_out is registered into m{src}_rdata and m{src}_rvalid is pulsed.
  - Writes produce no response.
- Reset values: every output is 0; cmd_q.valid=0; consec_cnt=0.

## Timing
- Accept cycle N: req & gnt.
- Cycle N+1: RAM is driven. A write commits at the rising edge that ends N+1.
- Cycle N+2: rvalid=1 with rdata for a read. Read latency is 2 cycles from acceptance.
- Throughput: one access per cycle, back-to-back with no bubbles; the source port may alternate every cycle.
- Read-after-write, same address, in consecutive accesses: the read in N+2 returns the new data, since the write committed at the end of N+1.
- Simultaneous write (port 0) and read (port 1) to the same address: serialized in grant order. The later access observes the earlier one.
- Unwritten locations read as 0; the RAM guarantees this.
- Reset asserted mid-operation:
  - ram_store drops immediately (asynchronous), so the pending write is abandoned.
  - The pending read produces no rvalid.
  - rdata clears to 0.
- First cycle after reset deassertion: arbitration proceeds normally with consec_cnt=0.
- Address wrap: none. The address is used verbatim and all 2^ADDR_W words are valid.

## Structure
- Package ram_arb_pkg holds:
  - ADDR_W and DATA_W defaults.
  - ram_cmd_t struct {valid, we, addr, wdata, src}.
  - Port index constants PORT_CORE=0 and PORT_DMA=1.
- Sub-module ram_arb_select: combinational grant logic plus the consec_cnt register, parameterized by MAX_CONSEC.
- Top level contains the cmd_q register, RAM drive and the read-return registers.

## Test plan
- Reset, then m0 write addr 0x010 data 0xDEADBEEF, then m0 read 0x010 -> m0_gnt in both accept cycles; m0_rvalid 2 cycles after the read accept with m0_rdata=0xDEADBEEF; m1_rvalid stays 0.
- Read of never-written addr 0xFFF via m1 -> m1_rvalid with m1_rdata=0x00000000.
- Both ports requesting continuously, MAX_CONSEC=4 -> grant pattern 0,0,0,0,1 repeating; every m1 request is served within 5 cycles.
- Back-to-back m0 write 0x020←0x1 and m1 read 0x020 in consecutive cycles -> m1_rdata=0x1 two cycles after the read accept.
- rst asserted in the cycle after a write is accepted to 0x030 (data 0x55) -> ram_store falls to 0 immediately; a later read of 0x030 returns its prior value 0; all outputs are 0 during reset.
- 16 back-to-back m1 reads of 0x000..0x00F, no m0 traffic -> 16 consecutive rvalid pulses, in order, with no bubbles.
